insight_regfile_snapshot_ctrl: RTL and testbench



---
 rtl/insight_snap_pkg.sv | 16 +
 rtl/insight_regfile_snapshot_ctrl_if.sv | 28 ++
 rtl/insight_snap_shadow.sv | 32 +++
 rtl/insight_regfile_snapshot_ctrl.sv | 129 ++++++++++++
 tb/tb_insight_regfile_snapshot_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/insight_snap_pkg.sv
// Shared types and constants for the register-file snapshot sequencer.
package insight_snap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } snap_state_e;

  localparam logic [4:0] HDR_IDX  = 5'd0;
  localparam logic [4:0] LAST_IDX = 5'd31;

  localparam int SEQ_W  = 16;
  localparam int DROP_W = 16;

endpackage

// File: rtl/insight_regfile_snapshot_ctrl_if.sv
// Beat stream port of the snapshot sequencer: valid/ready with index, payload and last flag.
interface insight_regfile_snapshot_ctrl_if #(
  parameter int XLEN = 32
) ();

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_idx;
  logic [XLEN-1:0] out_data;
  logic            out_last;

  modport master (
    output out_valid,
    output out_idx,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/insight_snap_shadow.sv
// Shadow copy of the tapped register file; loaded in parallel on capture, read by beat index.
module insight_snap_shadow #(
  parameter int XLEN  = 32,
  parameter int NREGS = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  capture_i,
  input  logic [NREGS*XLEN-1:0] regs_i,
  input  logic [4:0]            idx_i,
  output logic [XLEN-1:0]       data_o
);

  logic [NREGS*XLEN-1:0] buf_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_q <= '0;
    end else if (capture_i) begin
      buf_q <= regs_i;
    end
  end

  // idx 0 is the header slot and has no shadow entry
  always_comb begin
    data_o = '0;
    for (int k = 1; k <= NREGS; k++) begin
      if (idx_i == 5'(k)) data_o = buf_q[(k-1)*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/insight_regfile_snapshot_ctrl.sv
// Freezes the x1..x31 taps on request and streams a header plus 31 register beats.
module insight_regfile_snapshot_ctrl
  import insight_snap_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREGS*XLEN-1:0] regs_in,
  input  logic                  quiesce,
  input  logic                  snap_req,
  output logic                  busy,
  insight_regfile_snapshot_ctrl_if.master out_if
);

  snap_state_e       state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [4:0]        rd_idx;
  logic              vld_q, vld_d;
  logic              last_q, last_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic [XLEN-1:0]   shadow_data;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              capture;
  logic              hs;
  logic              drop_evt;

  assign rd_idx = ptr_q + 5'd1;

  insight_snap_shadow #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_shadow (
    .clock     (clock),
    .reset_n   (reset_n),
    .capture_i (capture),
    .regs_i    (regs_in),
    .idx_i     (rd_idx),
    .data_o    (shadow_data)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    vld_d    = vld_q;
    last_d   = last_q;
    data_d   = data_q;
    seq_d    = seq_q;
    drop_d   = drop_q;
    capture  = 1'b0;
    hs       = vld_q & out_if.out_ready;
    drop_evt = snap_req && (state_q != IDLE);

    if (drop_evt && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + DROP_W'(1);

    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = quiesce ? STREAM : ARM;
          capture = quiesce;
        end
      end
      ARM: begin
        if (quiesce) begin
          state_d = STREAM;
          capture = 1'b1;
        end
      end
      STREAM: begin
        if (hs) begin
          // header acceptance closes the drop window; a same-cycle drop opens the next one
          if (ptr_q == HDR_IDX) begin
            seq_d  = seq_q + SEQ_W'(1);
            drop_d = drop_evt ? DROP_W'(1) : '0;
          end
          if (ptr_q == LAST_IDX) begin
            state_d = IDLE;
            vld_d   = 1'b0;
            ptr_d   = HDR_IDX;
            last_d  = 1'b0;
            data_d  = '0;
          end else begin
            ptr_d  = rd_idx;
            data_d = shadow_data;
            last_d = (rd_idx == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // header is latched at capture so it stays stable while the sink stalls
    if (capture) begin
      vld_d  = 1'b1;
      ptr_d  = HDR_IDX;
      last_d = 1'b0;
      data_d = XLEN'({seq_q, drop_d});
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= HDR_IDX;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      seq_q   <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      drop_q  <= drop_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign out_if.out_valid = vld_q;
  assign out_if.out_idx   = ptr_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q;

endmodule

// File: tb/tb_insight_regfile_snapshot_ctrl.sv
// Bench for the snapshot sequencer: vector table, directed corner sequences and a frame-level reference model.
module tb_insight_regfile_snapshot_ctrl;

  localparam int XLEN  = 32;
  localparam int NREGS = 31;

  typedef struct packed {
    logic [4:0]  idx;
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    bit          req;
    bit          q;
    bit          rdy;
    bit          e_busy;
    bit          e_vld;
    logic [4:0]  e_idx;
    logic [31:0] e_data;
  } vec_t;

  typedef enum int { M_IDLE, M_WAIT, M_SEND } mph_e;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREGS*XLEN-1:0] regs_in;
  logic                  quiesce;
  logic                  snap_req;
  logic                  busy;

  insight_regfile_snapshot_ctrl_if #(.XLEN(XLEN)) ifc ();

  insight_regfile_snapshot_ctrl #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .regs_in  (regs_in),
    .quiesce  (quiesce),
    .snap_req (snap_req),
    .busy     (busy),
    .out_if   (ifc)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  beat_t       beats[$];

  // Frame-level reference: a whole frame image is built at capture time
  mph_e        m_ph;
  int          m_beat;
  logic [15:0] m_seq;
  logic [15:0] m_drop;
  logic [31:0] m_frame [32];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int k, input logic [31:0] v);
    regs_in[(k-1)*32 +: 32] = v;
  endtask

  task automatic model_reset();
    m_ph   = M_IDLE;
    m_beat = 0;
    m_seq  = 16'd0;
    m_drop = 16'd0;
  endtask

  task automatic model_edge();
    logic drop, hs, cap;
    if (!reset_n) begin
      model_reset();
      return;
    end
    drop = snap_req && (m_ph != M_IDLE);
    hs   = (m_ph == M_SEND) && ifc.out_ready;
    cap  = quiesce && ((m_ph == M_IDLE && snap_req) || m_ph == M_WAIT);
    if (drop && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    if (hs && m_beat == 0) begin
      m_seq  = m_seq + 16'd1;
      m_drop = drop ? 16'd1 : 16'd0;
    end
    if (hs) begin
      if (m_beat == 31) begin
        m_ph   = M_IDLE;
        m_beat = 0;
      end else begin
        m_beat++;
      end
    end else if (m_ph == M_IDLE && snap_req && !quiesce) begin
      m_ph = M_WAIT;
    end
    if (cap) begin
      m_frame[0] = {m_seq, m_drop};
      for (int k = 1; k <= 31; k++) m_frame[k] = regs_in[(k-1)*32 +: 32];
      m_beat = 0;
      m_ph   = M_SEND;
    end
  endtask

  task automatic check_model();
    logic ev;
    ev = (m_ph == M_SEND);
    cmp("ctl", 64'({busy, ifc.out_valid}), 64'({m_ph != M_IDLE, ev}));
    if (ev) cmp($sformatf("beat_x%0d", m_beat),
                64'({ifc.out_idx, ifc.out_last, ifc.out_data}),
                64'({5'(m_beat), m_beat == 31, m_frame[m_beat]}));
  endtask

  task automatic step();
    beat_t pre;
    logic  pv, pr;
    pv  = ifc.out_valid;
    pr  = ifc.out_ready;
    pre = {ifc.out_idx, ifc.out_last, ifc.out_data};
    if (pv && pr) beats.push_back(pre);
    @(posedge clock);
    model_edge();
    #1;
    if (pv && !pr && reset_n)
      cmp("hold", 64'({ifc.out_valid, ifc.out_idx, ifc.out_last, ifc.out_data}), 64'({1'b1, pre}));
    check_model();
  endtask

  task automatic start_frame();
    beats.delete();
    snap_req = 1'b1;
    quiesce  = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic drain(input bit rnd, output int n);
    n = 0;
    while (busy && n < 500) begin
      ifc.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    cmp("drain_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] beat_data(input int i);
    return (i < beats.size()) ? beats[i].data : 32'hxxxx_xxxx;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [31:0] saved [32];
    vec_t        tbl [9];

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_0000};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0000};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0001_0000};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0001_0000};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'h1000_0001};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 32'h1000_0001};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h1000_0002};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h1000_0003};

    reset_n       = 1'b0;
    snap_req      = 1'b0;
    quiesce       = 1'b0;
    ifc.out_ready = 1'b0;
    regs_in       = '0;
    for (int k = 1; k <= 31; k++) set_reg(k, 32'h1000_0000 + 32'(k));
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    cmp("reset_state", 64'({busy, ifc.out_valid, ifc.out_idx, ifc.out_last, ifc.out_data}), 64'd0);
    reset_n = 1'b1;

    // idle capture with ready held high
    ifc.out_ready = 1'b1;
    start_frame();
    cmp("first_valid", 64'(ifc.out_valid), 64'd1);
    drain(1'b0, n);
    cmp("idle_busy_fall", 64'(n), 64'd32);
    cmp("idle_nbeats", 64'(beats.size()), 64'd32);
    for (int i = 0; i < beats.size() && i < 32; i++)
      cmp($sformatf("idle_beat%0d", i), 64'(beats[i]),
          64'({5'(i), i == 31, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i)}));

    // vector table: arm, deferred capture, stall and resume
    beats.delete();
    for (int i = 0; i < 9; i++) begin
      snap_req      = tbl[i].req;
      quiesce       = tbl[i].q;
      ifc.out_ready = tbl[i].rdy;
      step();
      cmp($sformatf("vec%0d_ctl", i), 64'({busy, ifc.out_valid}), 64'({tbl[i].e_busy, tbl[i].e_vld}));
      if (tbl[i].e_vld)
        cmp($sformatf("vec%0d_beat", i), 64'({ifc.out_idx, ifc.out_data}), 64'({tbl[i].e_idx, tbl[i].e_data}));
    end
    snap_req = 1'b0;
    drain(1'b0, n);

    // deferred capture with a tap change while waiting for quiesce
    beats.delete();
    snap_req = 1'b1;
    quiesce  = 1'b0;
    step();
    snap_req = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      if (c == 4) set_reg(5, 32'hDEAD_BEEF);
      step();
    end
    cmp("arm_wait", 64'({busy, ifc.out_valid}), 64'(2'b10));
    quiesce = 1'b1;
    step();
    set_reg(5, 32'h5555_5555);
    set_reg(6, 32'hAAAA_AAAA);
    drain(1'b0, n);
    cmp("defer_hdr", 64'(beat_data(0)), 64'h0002_0000);
    cmp("defer_x5", 64'(beat_data(5)), 64'hDEAD_BEEF);
    cmp("defer_x6", 64'(beat_data(6)), 64'h1000_0006);

    // random backpressure with random taps that change after capture
    for (int k = 1; k <= 31; k++) begin
      saved[k] = $urandom;
      set_reg(k, saved[k]);
    end
    start_frame();
    for (int k = 1; k <= 31; k++) set_reg(k, ~saved[k]);
    drain(1'b1, n);
    cmp("bp_nbeats", 64'(beats.size()), 64'd32);
    for (int i = 0; i < beats.size() && i < 32; i++)
      cmp($sformatf("bp_beat%0d", i), 64'({beats[i].idx, beats[i].data}),
          64'({5'(i), (i == 0) ? 32'h0003_0000 : saved[i]}));

    // three drops mid-stream plus one on the final handshake
    start_frame();
    n = 0;
    while (busy && n < 100) begin
      ifc.out_ready = 1'b1;
      snap_req = ifc.out_valid && (ifc.out_idx inside {5'd5, 5'd10, 5'd15, 5'd31});
      step();
      n++;
    end
    snap_req = 1'b0;
    cmp("drop_frame_done", 64'(busy), 64'd0);
    start_frame();
    drain(1'b0, n);
    cmp("drop_hdr", 64'(beat_data(0)), 64'h0005_0004);
    start_frame();
    drain(1'b0, n);
    cmp("drop_clear_hdr", 64'(beat_data(0)), 64'h0006_0000);

    // drop counter saturation
    start_frame();
    ifc.out_ready = 1'b1;
    step();
    step();
    force dut.drop_q = 16'hFFFE;
    m_drop = 16'hFFFE;
    step();
    release dut.drop_q;
    for (int d = 0; d < 3; d++) begin
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
      step();
    end
    drain(1'b0, n);
    start_frame();
    drain(1'b0, n);
    cmp("sat_hdr", 64'(beat_data(0)), 64'h0008_FFFF);

    // sequence wrap
    force dut.seq_q = 16'hFFFF;
    m_seq = 16'hFFFF;
    step();
    release dut.seq_q;
    start_frame();
    drain(1'b0, n);
    cmp("wrap_hdr_ffff", 64'(beat_data(0)), 64'hFFFF_0000);
    start_frame();
    drain(1'b0, n);
    cmp("wrap_hdr_0000", 64'(beat_data(0)), 64'h0000_0000);

    // reset in the middle of a frame
    start_frame();
    ifc.out_ready = 1'b1;
    n = 0;
    while (!(ifc.out_valid && ifc.out_idx == 5'd10) && n < 50) begin
      step();
      n++;
    end
    cmp("reach_beat10", 64'(ifc.out_idx), 64'd10);
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_outputs", 64'({busy, ifc.out_valid, ifc.out_idx, ifc.out_last, ifc.out_data}), 64'd0);
    step();
    step();
    reset_n = 1'b1;
    start_frame();
    drain(1'b0, n);
    cmp("post_rst_hdr", 64'(beat_data(0)), 64'h0000_0000);
    cmp("post_rst_nbeats", 64'(beats.size()), 64'd32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
